// File: rtl/vdc_ramsched.sv
// Video RAM slot scheduler: refresh > display > round-robin(update, block).
// Latency: grant/address registered on the enable clk; read data returned on the next enable.
// Backpressure: requesters hold req until ack; one access per enable pulse.
module vdc_ramsched #(
  parameter int AW        = 16,
  parameter int RFSH_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 ram64k,
  input  logic                 reg_ram,
  input  logic [3:0]           reg_drr,
  input  logic                 line_start,
  input  logic                 disp_req,
  input  logic [AW-1:0]        disp_addr,
  output logic                 disp_ack,
  input  logic                 upd_req,
  input  logic                 upd_we,
  input  logic [AW-1:0]        upd_addr,
  input  logic [7:0]           upd_wdata,
  output logic                 upd_ack,
  input  logic                 blk_req,
  input  logic                 blk_we,
  input  logic [AW-1:0]        blk_addr,
  input  logic [7:0]           blk_wdata,
  output logic                 blk_ack,
  output logic [AW-1:0]        ram_addr,
  output logic                 ram_we,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  output logic [1:0]           rd_owner,
  output logic                 rfsh_active
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_UPD  = 2'd2,
    OWN_BLK  = 2'd3
  } owner_t;

  logic [RFSH_BITS-1:0] row;
  logic [3:0]           budget;
  logic                 rr_upd;      // 1: update port wins the next upd/blk tie
  logic                 pend_rd;     // a read was issued on the previous slot
  owner_t               pend_owner;

  logic [3:0]    budget_eff;
  logic          do_rfsh;
  owner_t        win;
  logic [AW-1:0] sel_addr;
  logic [AW-1:0] mask_addr;
  logic          sel_we;
  logic [7:0]    sel_wdata;
  logic          both;

  // Slot arbitration and address/data selection for the current slot.
  always_comb begin
    budget_eff = line_start ? reg_drr : budget;
    do_rfsh    = (budget_eff != 4'd0);
    both       = upd_req & blk_req;
    win        = OWN_NONE;
    sel_addr   = ram_addr;
    sel_we     = 1'b0;
    sel_wdata  = ram_wdata;
    if (do_rfsh) begin
      sel_addr = {{(AW-RFSH_BITS){1'b0}}, row};
    end else if (disp_req) begin
      win      = OWN_DISP;
      sel_addr = disp_addr;
    end else if (upd_req && (!blk_req || rr_upd)) begin
      win      = OWN_UPD;
      sel_addr = upd_addr;
      sel_we   = upd_we;
      if (upd_we) sel_wdata = upd_wdata;
    end else if (blk_req) begin
      win      = OWN_BLK;
      sel_addr = blk_addr;
      sel_we   = blk_we;
      if (blk_we) sel_wdata = blk_wdata;
    end
    // Without 64K RAM and 64K mode both set, the top two bits wrap at 16K.
    mask_addr = sel_addr;
    if (!(ram64k & reg_ram)) mask_addr[AW-1:AW-2] = 2'b00;
  end

  // Slot register: grants, RAM strobes, refresh pacing and read return pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_ack    <= 1'b0;
      upd_ack     <= 1'b0;
      blk_ack     <= 1'b0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= 8'h00;
      rd_data     <= 8'h00;
      rd_valid    <= 1'b0;
      rd_owner    <= 2'd0;
      rfsh_active <= 1'b0;
      row         <= '0;
      budget      <= 4'd0;
      rr_upd      <= 1'b1;
      pend_rd     <= 1'b0;
      pend_owner  <= OWN_NONE;
    end else begin
      disp_ack    <= 1'b0;
      upd_ack     <= 1'b0;
      blk_ack     <= 1'b0;
      ram_we      <= 1'b0;
      rd_valid    <= 1'b0;
      rfsh_active <= 1'b0;
      if (enable) begin
        rd_valid <= pend_rd;
        if (pend_rd) begin
          rd_data  <= ram_rdata;
          rd_owner <= pend_owner;
        end
        ram_addr    <= mask_addr;
        ram_we      <= sel_we;
        ram_wdata   <= sel_wdata;
        rfsh_active <= do_rfsh;
        disp_ack    <= (win == OWN_DISP);
        upd_ack     <= (win == OWN_UPD);
        blk_ack     <= (win == OWN_BLK);
        pend_rd     <= (win != OWN_NONE) && !sel_we;
        pend_owner  <= win;
        if (do_rfsh) begin
          budget <= budget_eff - 4'd1;
          row    <= row + 1'b1;
        end else begin
          budget <= budget_eff;
        end
        if (both && (win == OWN_UPD)) rr_upd <= 1'b0;
        if (both && (win == OWN_BLK)) rr_upd <= 1'b1;
      end else if (line_start) begin
        budget <= reg_drr;
      end
    end
  end

endmodule
